// File: rtl/cpu_opponent_sched.sv
// rtl/cpu_opponent_sched.sv - randomised, frame-paced action scheduler for the CPU fencer
module cpu_opponent_sched #(
  parameter int         MIN_DELAY  = 8,
  parameter int         DELAY_BITS = 4,
  parameter int         COOLDOWN   = 4,
  parameter logic [7:0] FAR_ADV    = 8'd160,
  parameter logic [7:0] FAR_RET    = 8'd208,
  parameter logic [7:0] FAR_ATK    = 8'd232,
  parameter logic [7:0] NEAR_ATK   = 8'd128,
  parameter logic [7:0] NEAR_PAR   = 8'd192,
  parameter logic [7:0] NEAR_RET   = 8'd240
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic        frame_tick_in,
  input  logic [15:0] rand_in,
  input  logic        near_in,
  input  logic        action_ready_in,
  output logic        action_valid_out,
  output logic [1:0]  action_out,
  output logic        busy_out,
  output logic [7:0]  frames_left_out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_DECIDE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_COOL   = 3'd4;

  localparam logic [1:0] ACT_ADVANCE = 2'd0;
  localparam logic [1:0] ACT_RETREAT = 2'd1;
  localparam logic [1:0] ACT_ATTACK  = 2'd2;
  localparam logic [1:0] ACT_PARRY   = 2'd3;

  logic [2:0] state, state_n;
  logic [7:0] cnt_n;
  logic       valid_n;
  logic [1:0] act_n;
  logic [1:0] decision;
  logic [7:0] r;
  logic       unused_rand;

  // Only the low delay bits and the top byte matter; the rest is deliberately ignored.
  assign unused_rand = ^rand_in;
  assign r = rand_in[15:8];

  always_comb begin
    decision = ACT_ADVANCE;
    if (!near_in) begin
      if (r < FAR_ADV)      decision = ACT_ADVANCE;
      else if (r < FAR_RET) decision = ACT_RETREAT;
      else if (r < FAR_ATK) decision = ACT_ATTACK;
      else                  decision = ACT_PARRY;
    end else begin
      if (r < NEAR_ATK)      decision = ACT_ATTACK;
      else if (r < NEAR_PAR) decision = ACT_PARRY;
      else if (r < NEAR_RET) decision = ACT_RETREAT;
      else                   decision = ACT_ADVANCE;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = frames_left_out;
    valid_n = action_valid_out;
    act_n   = action_out;
    case (state)
      S_IDLE: begin
        if (enable_in) begin
          cnt_n   = 8'(MIN_DELAY) + 8'(rand_in[DELAY_BITS-1:0]);
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!enable_in) begin
          state_n = S_IDLE;
          cnt_n   = 8'd0;
        end else if (frame_tick_in) begin
          cnt_n = frames_left_out - 8'd1;
          if (frames_left_out == 8'd1) state_n = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (!enable_in) begin
          state_n = S_IDLE;
          cnt_n   = 8'd0;
        end else begin
          act_n   = decision;
          valid_n = 1'b1;
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        // A simultaneous withdraw and accept still counts as delivered, but re-arms via IDLE.
        if (!enable_in || action_ready_in) valid_n = 1'b0;
        if (!enable_in || (action_ready_in && COOLDOWN == 0)) begin
          state_n = S_IDLE;
          cnt_n   = 8'd0;
        end else if (action_ready_in) begin
          state_n = S_COOL;
          cnt_n   = 8'(COOLDOWN);
        end
      end
      S_COOL: begin
        if (!enable_in) begin
          state_n = S_IDLE;
          cnt_n   = 8'd0;
        end else if (frame_tick_in) begin
          cnt_n = frames_left_out - 8'd1;
          if (frames_left_out == 8'd1) state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = 8'd0;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= S_IDLE;
      frames_left_out  <= 8'd0;
      action_valid_out <= 1'b0;
      action_out       <= 2'd0;
      busy_out         <= 1'b0;
    end else begin
      state            <= state_n;
      frames_left_out  <= cnt_n;
      action_valid_out <= valid_n;
      action_out       <= act_n;
      busy_out         <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_cpu_opponent_sched.sv
// tb/tb_cpu_opponent_sched.sv - directed vector bench for cpu_opponent_sched
module tb_cpu_opponent_sched;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        enable_in;
  logic        frame_tick_in;
  logic [15:0] rand_in;
  logic        near_in;
  logic        action_ready_in;
  logic        action_valid_out, action_valid_z;
  logic [1:0]  action_out, action_z;
  logic        busy_out, busy_z;
  logic [7:0]  frames_left_out, frames_left_z;

  always #5 clk_in = ~clk_in;

  cpu_opponent_sched #(.MIN_DELAY(8), .DELAY_BITS(4), .COOLDOWN(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in), .frame_tick_in(frame_tick_in),
    .rand_in(rand_in), .near_in(near_in), .action_ready_in(action_ready_in),
    .action_valid_out(action_valid_out), .action_out(action_out), .busy_out(busy_out),
    .frames_left_out(frames_left_out)
  );

  cpu_opponent_sched #(.MIN_DELAY(8), .DELAY_BITS(4), .COOLDOWN(0)) dut_z (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in), .frame_tick_in(frame_tick_in),
    .rand_in(rand_in), .near_in(near_in), .action_ready_in(action_ready_in),
    .action_valid_out(action_valid_z), .action_out(action_z), .busy_out(busy_z),
    .frames_left_out(frames_left_z)
  );

  typedef struct {
    logic [15:0] rnd;
    logic        near;
    logic [1:0]  act;
    int          delay;
  } vec_t;

  vec_t vecs[12];
  int   n_checks = 0;
  int   n_fail = 0;
  logic saw_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; holds the tick for exactly one posedge, returns at the next negedge.
  task automatic step(input logic tk);
    frame_tick_in = tk;
    @(negedge clk_in);
    frame_tick_in = 1'b0;
    if (action_valid_out) saw_valid = 1'b1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    enable_in = 1'b0;
    action_ready_in = 1'b0;
    repeat (3) step(1'b0);
    rst_in = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{16'hA005, 1'b0, 2'd1, 13};
    vecs[1]  = '{16'h7F00, 1'b1, 2'd2, 8};
    vecs[2]  = '{16'hF000, 1'b1, 2'd0, 8};
    vecs[3]  = '{16'h0000, 1'b0, 2'd0, 8};
    vecs[4]  = '{16'hCF0F, 1'b0, 2'd1, 23};
    vecs[5]  = '{16'hD000, 1'b0, 2'd2, 8};
    vecs[6]  = '{16'hE800, 1'b0, 2'd3, 8};
    vecs[7]  = '{16'hE703, 1'b0, 2'd2, 11};
    vecs[8]  = '{16'h8000, 1'b1, 2'd3, 8};
    vecs[9]  = '{16'hBF00, 1'b1, 2'd3, 8};
    vecs[10] = '{16'hC001, 1'b1, 2'd1, 9};
    vecs[11] = '{16'hEF00, 1'b1, 2'd1, 8};

    rst_in = 1'b1; enable_in = 1'b0; frame_tick_in = 1'b0; rand_in = 16'h0;
    near_in = 1'b0; action_ready_in = 1'b0; saw_valid = 1'b0;
    @(negedge clk_in);

    // Reset state, then reset applied in the middle of WAIT.
    do_reset();
    check("rst_valid", action_valid_out, 0);
    check("rst_action", action_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_frames", frames_left_out, 0);
    enable_in = 1'b1;
    step(1'b0);
    repeat (3) step(1'b1);
    check("midwait_frames", frames_left_out, 5);
    rst_in = 1'b1;
    repeat (3) step(1'b0);
    check("midrst_busy", busy_out, 0);
    check("midrst_frames", frames_left_out, 0);
    check("midrst_valid", action_valid_out, 0);
    rst_in = 1'b0; enable_in = 1'b0; saw_valid = 1'b0;
    repeat (10) step(1'b1);
    check("disabled_busy", busy_out, 0);
    check("disabled_frames", frames_left_out, 0);
    check("disabled_no_valid", saw_valid, 0);

    // Decision table: full delay, handshake with ready held high, then cooldown.
    for (int i = 0; i < 12; i++) begin
      do_reset();
      rand_in = vecs[i].rnd; near_in = vecs[i].near; action_ready_in = 1'b1; enable_in = 1'b1;
      step(1'b0);
      check($sformatf("v%0d_busy_rise", i), busy_out, 1);
      check($sformatf("v%0d_load", i), frames_left_out, vecs[i].delay);
      for (int k = 1; k <= vecs[i].delay; k++) begin
        step(1'b1);
        check($sformatf("v%0d_wait_frames%0d", i, k), frames_left_out, vecs[i].delay - k);
        check($sformatf("v%0d_wait_valid%0d", i, k), action_valid_out, 0);
      end
      step(1'b0);
      check($sformatf("v%0d_valid", i), action_valid_out, 1);
      check($sformatf("v%0d_action", i), action_out, vecs[i].act);
      check($sformatf("v%0d_z_action", i), action_z, vecs[i].act);
      step(1'b0);
      check($sformatf("v%0d_valid_drop", i), action_valid_out, 0);
      check($sformatf("v%0d_cool_load", i), frames_left_out, 4);
      check($sformatf("v%0d_cool_busy", i), busy_out, 1);
      check($sformatf("v%0d_z_idle", i), busy_z, 0);
      check($sformatf("v%0d_z_valid", i), action_valid_z, 0);
      for (int k = 1; k <= 4; k++) begin
        step(1'b1);
        check($sformatf("v%0d_cool_frames%0d", i, k), frames_left_out, 4 - k);
        check($sformatf("v%0d_cool_busy%0d", i, k), busy_out, (k < 4) ? 1 : 0);
      end
      check($sformatf("v%0d_hold_action", i), action_out, vecs[i].act);
      enable_in = 1'b0;
    end

    // Backpressure: valid and action held, ticks ignored, rand changes ignored.
    do_reset();
    rand_in = 16'h0000; near_in = 1'b0; enable_in = 1'b1;
    step(1'b0);
    repeat (8) step(1'b1);
    step(1'b0);
    check("bp_valid", action_valid_out, 1);
    for (int k = 0; k < 5; k++) begin
      rand_in = 16'($urandom);
      step(1'b1);
      check($sformatf("bp_hold_valid%0d", k), action_valid_out, 1);
      check($sformatf("bp_hold_action%0d", k), action_out, 0);
      check($sformatf("bp_hold_frames%0d", k), frames_left_out, 0);
    end
    action_ready_in = 1'b1;
    step(1'b0);
    check("bp_valid_drop", action_valid_out, 0);
    check("bp_cool_load", frames_left_out, 4);
    enable_in = 1'b0;
    step(1'b0);
    check("bp_cool_abort_busy", busy_out, 0);
    check("bp_cool_abort_frames", frames_left_out, 0);

    // Abort during WAIT after 3 of 8 ticks.
    do_reset();
    rand_in = 16'h0000; action_ready_in = 1'b1; enable_in = 1'b1;
    step(1'b0);
    repeat (3) step(1'b1);
    enable_in = 1'b0; saw_valid = 1'b0;
    step(1'b0);
    check("abort_wait_busy", busy_out, 0);
    check("abort_wait_frames", frames_left_out, 0);
    repeat (12) step(1'b1);
    check("abort_wait_no_valid", saw_valid, 0);

    // Abort during HOLD withdraws the offer.
    do_reset();
    rand_in = 16'h0000; action_ready_in = 1'b0; enable_in = 1'b1;
    step(1'b0);
    repeat (8) step(1'b1);
    step(1'b0);
    check("abort_hold_pre_valid", action_valid_out, 1);
    enable_in = 1'b0;
    step(1'b0);
    check("abort_hold_valid", action_valid_out, 0);
    check("abort_hold_busy", busy_out, 0);
    check("abort_hold_frames", frames_left_out, 0);

    // Tick coincident with IDLE->WAIT is not counted; COOLDOWN=0 goes straight to IDLE.
    do_reset();
    rand_in = 16'h0000; near_in = 1'b0; action_ready_in = 1'b1; enable_in = 1'b1;
    step(1'b1);
    check("bnd_load", frames_left_out, 8);
    repeat (7) step(1'b1);
    check("bnd_frames_7", frames_left_out, 1);
    step(1'b0);
    step(1'b0);
    check("bnd_no_early_valid", action_valid_out, 0);
    step(1'b1);
    check("bnd_decide_valid", action_valid_out, 0);
    step(1'b0);
    check("bnd_valid", action_valid_out, 1);
    check("bnd_action", action_out, 0);
    check("bnd_z_valid", action_valid_z, 1);
    step(1'b0);
    check("bnd_z_idle_busy", busy_z, 0);
    check("bnd_z_idle_valid", action_valid_z, 0);
    check("bnd_cool_frames", frames_left_out, 4);
    enable_in = 1'b0;
    step(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_opponent_sched.md
# cpu_opponent_sched

Randomised action scheduler for the CPU fencer. It consumes the free-running 16-bit pseudo-random word from the LFSR stage and waits a random number of video frames. It then picks a weighted-random fencing action and offers it to the opponent controller over a valid/ready handshake, followed by a fixed cooldown. It sits directly downstream of the LFSR and upstream of the opponent movement/attack logic.

## Interface
Parameters:
- MIN_DELAY, 8: minimum wait in frame ticks; must be ≥1.
- DELAY_BITS, 4: number of random bits added to the delay. MIN_DELAY + 2^DELAY_BITS − 1 must be ≤ 255.
- COOLDOWN, 4: frame ticks after an accepted action before re-arming; 0 allowed.
- FAR_ADV / FAR_RET / FAR_ATK, 160 / 208 / 232: ascending 8-bit thresholds used when far.
- NEAR_ATK / NEAR_PAR / NEAR_RET, 128 / 192 / 240: ascending 8-bit thresholds used when near.

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: synchronous, active-high reset.
- enable_in, input, 1: scheduler armed; low aborts to IDLE.
- frame_tick_in, input, 1: one-cycle pulse per video frame.
- rand_in, input, 16: LFSR output word.
- near_in, input, 1: opponents within striking distance.
- action_ready_in, input, 1: consumer accepts the action.
- action_valid_out, output, 1: action offered.
- action_out, output, 2: action code. 0 = ADVANCE, 1 = RETREAT, 2 = ATTACK, 3 = PARRY.
- busy_out, output, 1: state ≠ IDLE.
- frames_left_out, output, 8: current value of the down-counter.

## Operation
- States: IDLE, WAIT, DECIDE, HOLD, COOL. All outputs are registered.
- Reset: state = IDLE; action_valid_out, action_out, busy_out and frames_left_out are all 0.
- IDLE with enable_in = 1:
  - counter ← MIN_DELAY + rand_in[DELAY_BITS−1:0] (8-bit, zero-extended).
  - Go to WAIT.
- WAIT:
  - Each frame_tick_in decrements the counter.
  - A tick arriving while counter = 1 sets counter to 0 and moves to DECIDE.
  - A frame_tick_in in the same cycle as the IDLE→WAIT transition is ignored. The delay therefore equals exactly D ticks seen in WAIT.
- DECIDE (one cycle): r = rand_in[15:8], sampled this cycle.
  - Far (near_in = 0): r < FAR_ADV gives ADVANCE; else r < FAR_RET gives RETREAT; else r < FAR_ATK gives ATTACK; else PARRY.
  - Near (near_in = 1): r < NEAR_ATK gives ATTACK; else r < NEAR_PAR gives PARRY; else r < NEAR_RET gives RETREAT; else ADVANCE.
  - Register action_out, set action_valid_out = 1, go to HOLD.
- HOLD:
  - action_valid_out stays 1 and action_out stays stable until action_ready_in = 1.
  - On acceptance, action_valid_out drops on the next edge.
  - After acceptance, go to COOL with counter ← COOLDOWN, or go straight to IDLE if COOLDOWN = 0.
  - Frame ticks are ignored in HOLD.
- COOL: a tick while counter = 1 moves to IDLE. Otherwise each tick decrements the counter.
- enable_in = 0 in any non-IDLE state: next edge goes to IDLE, action_valid_out = 0, counter = 0. No action is emitted.
  - Disable in DECIDE suppresses the action.
  - Disable in HOLD withdraws it.
  - If enable_in = 0 and action_ready_in = 1 arrive together in HOLD, the action counts as accepted. The block still goes to IDLE.
- action_out holds its last value when not valid. The consumer qualifies it with action_valid_out.

## Timing
- Edge E: IDLE→WAIT. The D-th tick in WAIT is at edge T, where the state becomes DECIDE. At T+1 the state is HOLD and action_valid_out = 1. Latency from the final tick to valid is 2 cycles.
- The handshake completes at the first edge with valid & ready. Valid is low in the following cycle.
- busy_out rises the cycle after enable is seen in IDLE. It falls the cycle the state returns to IDLE.
- frames_left_out mirrors the counter every cycle, including during COOL.
- rand_in is sampled only on the IDLE→WAIT edge and in DECIDE. Intermediate values have no effect.

## Test plan
- Reset: assert rst_in for 3 cycles mid-WAIT → all outputs 0 and state IDLE. Ticks with enable_in = 0 → no activity.
- Far: rand_in = 16'hA005 held, near_in = 0, ready_in = 1 → delay 13 ticks; action_out = 1 (RETREAT, r = 160); valid for exactly 1 cycle; 4 cooldown ticks, then IDLE.
- Near: rand_in = 16'h7F00, near_in = 1 → delay 8; action_out = 2 (ATTACK, r = 127). Repeat with 16'hF000 → ADVANCE (r = 240).
- Backpressure: ready_in low for 5 cycles after valid → valid held, action_out stable, frames_left_out = 0. Ready high → valid low next cycle; COOL loads 4.
- Abort: drop enable_in after 3 of 8 ticks → IDLE next edge; action_valid_out never rises. Also drop enable_in in HOLD → valid cleared next edge.
- Boundary: frame_tick_in coincident with the IDLE→WAIT edge, rand_in = 0 → the tick is not counted; valid follows the 8th later tick; action_out = 0 (ADVANCE). With COOLDOWN = 0 → IDLE on the edge after acceptance.
